// File: rtl/trojan_mon_pkg.sv
// Shared types and helpers for the trojan monitor: FSM state encoding,
// captured-vector width and the golden reference function.
package trojan_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        ALERT = 2'd2
    } state_e;

    localparam int VEC_W = 6;

    function automatic logic golden_fn(input logic a, input logic b, input logic c);
        return (a & b) | c;
    endfunction

endpackage

// File: rtl/trojan_golden.sv
// Combinational golden model of the observed DUT: g = (a & b) | c.
module trojan_golden
    import trojan_mon_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic g
);

    assign g = golden_fn(a, b, c);

endmodule

// File: rtl/trojan_monitor.sv
// Runtime monitor comparing an observed output against its golden function;
// counts mismatches and trigger events and raises a sticky alarm.
// Define TROJAN_MON_LOG_EN to add the first-mismatch capture register (first_vec).
module trojan_monitor
    import trojan_mon_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int ALERT_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             t1,
    input  logic             t2,
    input  logic             y,
    input  logic             en,
    input  logic             clr,
    output logic             alarm,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] mismatch_cnt,
`ifdef TROJAN_MON_LOG_EN
    output logic [CNT_W-1:0] trig_cnt,
    output logic [VEC_W-1:0] first_vec
`else
    output logic [CNT_W-1:0] trig_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ALERT_THRESH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
    logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;
    logic             g;
    logic             mismatch;
    logic             trig;
    logic             thresh_hit;

    trojan_golden u_golden (
        .a (a),
        .b (b),
        .c (c),
        .g (g)
    );

    assign mismatch   = en & (y != g);
    assign trig       = en & t1 & t2;
    assign thresh_hit = mismatch & (mismatch_cnt_d >= THRESH);

    always_comb begin
        // NOTE: defaults first so every path assigns the _d signals and no latch is inferred.
        mismatch_cnt_d = mismatch_cnt_q;
        trig_cnt_d     = trig_cnt_q;
        if (clr) begin
            mismatch_cnt_d = '0;
            trig_cnt_d     = '0;
        end else begin
            if (mismatch && mismatch_cnt_q != CNT_MAX) mismatch_cnt_d = mismatch_cnt_q + 1'b1;
            if (trig && trig_cnt_q != CNT_MAX)         trig_cnt_d     = trig_cnt_q + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            mismatch_cnt_q <= '0;
            trig_cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q        <= state_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            trig_cnt_q     <= trig_cnt_d;
        end
    end

    // Next-state logic; threshold uses the count including this cycle's mismatch
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (thresh_hit) state_d = ALERT;
                         else if (trig)  state_d = ARMED;
                ARMED:   if (thresh_hit) state_d = ALERT;
                ALERT:   state_d = ALERT;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        state        = state_q;
        alarm        = (state_q == ALERT);
        mismatch_cnt = mismatch_cnt_q;
        trig_cnt     = trig_cnt_q;
    end

`ifdef TROJAN_MON_LOG_EN
    logic [VEC_W-1:0] first_vec_q, first_vec_d;

    // A mismatch vector is never all-zero, and the count only returns to zero on clr/rst
    always_comb begin
        first_vec_d = first_vec_q;
        if (clr)                                     first_vec_d = '0;
        else if (mismatch && mismatch_cnt_q == '0)   first_vec_d = {a, b, c, t1, t2, y};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) first_vec_q <= '0;
        else     first_vec_q <= first_vec_d;
    end

    assign first_vec = first_vec_q;
`endif

endmodule
